// File: rtl/park_gate_ctrl.sv
// Parking-lot entry gate controller: barrier sequencing FSM, a cycle timer
// for the OPENING/PASSING timeouts, the occupancy counter with a loadable
// capacity, and sticky error flags.
//
// state    | code | meaning
// IDLE     | 0    | barrier closed, waiting for a car while lot not full
// OPENING  | 1    | open requested, waiting for gate_ack=1
// PASSING  | 2    | barrier open, waiting for the car to enter
// CLOSING  | 3    | close requested, waiting for gate_ack=0
module park_gate_ctrl #(
    parameter int TIMEOUT_CYC = 200,
    parameter int DEFAULT_CAP = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_evt,
    input  logic       dec_evt,
    input  logic       car_waiting,
    input  logic       gate_ack,
    input  logic       cap_load,
    input  logic [3:0] cap_value,
    input  logic       err_clr,
    output logic       gate_open,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       ovf_err,
    output logic       unf_err,
    output logic       timeout_err,
    output logic [2:0] debug_state
);

    localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC);
    localparam logic [3:0]    CAP_RST   = 4'(DEFAULT_CAP);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPENING = 3'd1,
        ST_PASSING = 3'd2,
        ST_CLOSING = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            gate_open_q, gate_open_d;
    logic [3:0]      count_q, count_d;
    logic [3:0]      cap_q, cap_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            tmo_q, tmo_d;
    logic            timeout_set;
    logic            ovf_set;
    logic            unf_set;
    logic            timer_done;

    // Full/empty come straight from the registered count and capacity.
    assign full  = (count_q >= cap_q);
    assign empty = (count_q == 4'd0);

    assign timer_done = (timer_q == TIMER_MAX);

    // Gate FSM next state; undefined codes fall back to IDLE.
    always_comb begin
        state_d     = state_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (car_waiting && !full) state_d = ST_OPENING;
            end
            ST_OPENING: begin
                if (gate_ack) begin
                    state_d = ST_PASSING;
                end else if (timer_done) begin
                    state_d     = ST_CLOSING;
                    timeout_set = 1'b1;
                end
            end
            ST_PASSING: begin
                // A car that never shows up is not an error, just close.
                if (inc_evt || timer_done) state_d = ST_CLOSING;
            end
            ST_CLOSING: begin
                if (!gate_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Barrier request is registered and follows the upcoming state.
    always_comb begin
        gate_open_d = (state_d == ST_OPENING) || (state_d == ST_PASSING);
    end

    // Cycle timer: cleared on any state change, saturating up-count while
    // waiting in OPENING or PASSING.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == ST_OPENING || state_q == ST_PASSING) && !timer_done) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Capacity register; a zero capacity is meaningless and is ignored.
    always_comb begin
        cap_d = cap_q;
        if (cap_load && (cap_value != 4'd0)) cap_d = cap_value;
    end

    // Occupancy counter, active in every FSM state. Simultaneous entry and
    // exit cancel out. count < cap <= 15 guarantees no wrap on increment.
    always_comb begin
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (inc_evt && !dec_evt) begin
            if (count_q < cap_q) count_d = count_q + 4'd1;
            else                 ovf_set = 1'b1;
        end else if (dec_evt && !inc_evt) begin
            if (count_q != 4'd0) count_d = count_q - 4'd1;
            else                 unf_set = 1'b1;
        end
    end

    // Sticky errors: a new error in the same cycle beats err_clr.
    always_comb begin
        ovf_d = ovf_set     | (ovf_q & ~err_clr);
        unf_d = unf_set     | (unf_q & ~err_clr);
        tmo_d = timeout_set | (tmo_q & ~err_clr);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            gate_open_q <= 1'b0;
            count_q     <= 4'd0;
            cap_q       <= CAP_RST;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            gate_open_q <= gate_open_d;
            count_q     <= count_d;
            cap_q       <= cap_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            tmo_q       <= tmo_d;
        end
    end

    assign gate_open   = gate_open_q;
    assign count       = count_q;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
    assign timeout_err = tmo_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Directed self-checking bench for park_gate_ctrl.
module tb_park_gate_ctrl;

    localparam int TMO = 200;

    logic       clk;
    logic       reset;
    logic       inc_evt;
    logic       dec_evt;
    logic       car_waiting;
    logic       gate_ack;
    logic       cap_load;
    logic [3:0] cap_value;
    logic       err_clr;
    logic       gate_open;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       unf_err;
    logic       timeout_err;
    logic [2:0] debug_state;

    int tests  = 0;
    int failed = 0;

    park_gate_ctrl #(.TIMEOUT_CYC(TMO), .DEFAULT_CAP(15)) dut (
        .clk(clk), .reset(reset), .inc_evt(inc_evt), .dec_evt(dec_evt),
        .car_waiting(car_waiting), .gate_ack(gate_ack), .cap_load(cap_load),
        .cap_value(cap_value), .err_clr(err_clr), .gate_open(gate_open),
        .count(count), .full(full), .empty(empty), .ovf_err(ovf_err),
        .unf_err(unf_err), .timeout_err(timeout_err), .debug_state(debug_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic i, input logic d);
        inc_evt = i;
        dec_evt = d;
        step();
        inc_evt = 1'b0;
        dec_evt = 1'b0;
    endtask

    task automatic load_cap(input logic [3:0] v);
        cap_load  = 1'b1;
        cap_value = v;
        step();
        cap_load  = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inc_evt = 0; dec_evt = 0; car_waiting = 0; gate_ack = 0;
        cap_load = 0; cap_value = 0; err_clr = 0;
        #12;
        tests++; if (debug_state !== 3'd0) begin failed++; $display("FAIL rst_state got %0d exp 0", debug_state); end
        tests++; if (gate_open !== 1'b0) begin failed++; $display("FAIL rst_gate got %b exp 0", gate_open); end
        tests++; if (count !== 4'd0) begin failed++; $display("FAIL rst_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL rst_flags got empty=%b full=%b exp 1/0", empty, full); end
        tests++; if ({ovf_err, unf_err, timeout_err} !== 3'b000) begin failed++; $display("FAIL rst_errs got %b exp 000", {ovf_err, unf_err, timeout_err}); end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_normal_entry();
        car_waiting = 1'b1;
        step();
        car_waiting = 1'b0;
        tests++; if (debug_state !== 3'd1 || gate_open !== 1'b1) begin failed++; $display("FAIL entry_opening got st=%0d go=%b exp 1/1", debug_state, gate_open); end
        step();
        step();
        tests++; if (debug_state !== 3'd1) begin failed++; $display("FAIL entry_wait_ack got %0d exp 1", debug_state); end
        gate_ack = 1'b1;
        step();
        tests++; if (debug_state !== 3'd2 || gate_open !== 1'b1) begin failed++; $display("FAIL entry_passing got st=%0d go=%b exp 2/1", debug_state, gate_open); end
        pulse(1'b1, 1'b0);
        tests++; if (debug_state !== 3'd3 || gate_open !== 1'b0) begin failed++; $display("FAIL entry_closing got st=%0d go=%b exp 3/0", debug_state, gate_open); end
        tests++; if (count !== 4'd1 || empty !== 1'b0) begin failed++; $display("FAIL entry_count got %0d empty=%b exp 1/0", count, empty); end
        gate_ack = 1'b0;
        step();
        tests++; if (debug_state !== 3'd0 || gate_open !== 1'b0) begin failed++; $display("FAIL entry_idle got st=%0d go=%b exp 0/0", debug_state, gate_open); end
    endtask

    task automatic test_capacity();
        pulse(1'b0, 1'b1);
        load_cap(4'd2);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        tests++; if (count !== 4'd2 || full !== 1'b1 || ovf_err !== 1'b0) begin failed++; $display("FAIL cap_fill got cnt=%0d full=%b ovf=%b exp 2/1/0", count, full, ovf_err); end
        pulse(1'b1, 1'b0);
        tests++; if (count !== 4'd2 || ovf_err !== 1'b1) begin failed++; $display("FAIL cap_ovf got cnt=%0d ovf=%b exp 2/1", count, ovf_err); end
        car_waiting = 1'b1;
        step(); step(); step();
        tests++; if (debug_state !== 3'd0 || gate_open !== 1'b0) begin failed++; $display("FAIL cap_hold_idle got st=%0d go=%b exp 0/0", debug_state, gate_open); end
        car_waiting = 1'b0;
        load_cap(4'd0);
        pulse(1'b0, 1'b1);
        tests++; if (count !== 4'd1 || full !== 1'b0) begin failed++; $display("FAIL cap_zero_ignored got cnt=%0d full=%b exp 1/0", count, full); end
        pulse(1'b1, 1'b0);
        load_cap(4'd1);
        tests++; if (count !== 4'd2 || full !== 1'b1) begin failed++; $display("FAIL cap_lowered got cnt=%0d full=%b exp 2/1", count, full); end
        pulse(1'b0, 1'b1);
        tests++; if (count !== 4'd1 || full !== 1'b1) begin failed++; $display("FAIL cap_low_dec got cnt=%0d full=%b exp 1/1", count, full); end
        pulse(1'b0, 1'b1);
        tests++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL cap_low_empty got cnt=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
        err_clr = 1'b1;
        pulse(1'b0, 1'b1);
        err_clr = 1'b0;
        tests++; if (ovf_err !== 1'b0 || unf_err !== 1'b1) begin failed++; $display("FAIL set_beats_clr got ovf=%b unf=%b exp 0/1", ovf_err, unf_err); end
        clear_errs();
        tests++; if (unf_err !== 1'b0) begin failed++; $display("FAIL clr_unf got %b exp 0", unf_err); end
    endtask

    task automatic test_underflow_simul();
        load_cap(4'd15);
        pulse(1'b0, 1'b1);
        tests++; if (count !== 4'd0 || unf_err !== 1'b1) begin failed++; $display("FAIL unf got cnt=%0d unf=%b exp 0/1", count, unf_err); end
        clear_errs();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        tests++; if (count !== 4'd1 || {ovf_err, unf_err} !== 2'b00) begin failed++; $display("FAIL simul got cnt=%0d errs=%b exp 1/00", count, {ovf_err, unf_err}); end
    endtask

    task automatic test_full_no_abort();
        load_cap(4'd2);
        car_waiting = 1'b1;
        step();
        car_waiting = 1'b0;
        pulse(1'b1, 1'b0);
        tests++; if (debug_state !== 3'd1 || full !== 1'b1 || count !== 4'd2) begin failed++; $display("FAIL noabort_open got st=%0d full=%b cnt=%0d exp 1/1/2", debug_state, full, count); end
        gate_ack = 1'b1;
        step();
        tests++; if (debug_state !== 3'd2 || gate_open !== 1'b1) begin failed++; $display("FAIL noabort_pass got st=%0d go=%b exp 2/1", debug_state, gate_open); end
        pulse(1'b1, 1'b0);
        tests++; if (debug_state !== 3'd3 || count !== 4'd2 || ovf_err !== 1'b1) begin failed++; $display("FAIL noabort_close got st=%0d cnt=%0d ovf=%b exp 3/2/1", debug_state, count, ovf_err); end
        gate_ack = 1'b0;
        step();
        clear_errs();
        load_cap(4'd15);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        int n;
        car_waiting = 1'b1;
        step();
        car_waiting = 1'b0;
        n = 0;
        while (debug_state == 3'd1 && n < TMO + 5) begin
            step();
            n++;
        end
        tests++; if (debug_state !== 3'd3 || n < TMO || n > TMO + 1) begin failed++; $display("FAIL open_timeout got st=%0d after %0d cycles exp 3 after %0d..%0d", debug_state, n, TMO, TMO + 1); end
        tests++; if (timeout_err !== 1'b1 || gate_open !== 1'b0) begin failed++; $display("FAIL open_tmo_err got err=%b go=%b exp 1/0", timeout_err, gate_open); end
        step();
        tests++; if (debug_state !== 3'd0) begin failed++; $display("FAIL tmo_idle got %0d exp 0", debug_state); end
        clear_errs();
        tests++; if (timeout_err !== 1'b0) begin failed++; $display("FAIL tmo_clr got %b exp 0", timeout_err); end
        car_waiting = 1'b1;
        step();
        gate_ack = 1'b1;
        step();
        car_waiting = 1'b0;
        n = 0;
        while (debug_state == 3'd2 && n < TMO + 5) begin
            step();
            n++;
        end
        tests++; if (debug_state !== 3'd3 || n < TMO || n > TMO + 1 || timeout_err !== 1'b0) begin failed++; $display("FAIL pass_timeout got st=%0d n=%0d err=%b exp 3 n=%0d..%0d err=0", debug_state, n, timeout_err, TMO, TMO + 1); end
        gate_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        load_cap(4'd10);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        car_waiting = 1'b1;
        step();
        gate_ack = 1'b1;
        step();
        tests++; if (debug_state !== 3'd2 || count !== 4'd5) begin failed++; $display("FAIL mid_setup got st=%0d cnt=%0d exp 2/5", debug_state, count); end
        gate_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++; if (gate_open !== 1'b0 || count !== 4'd0 || debug_state !== 3'd0 || empty !== 1'b1) begin failed++; $display("FAIL async_reset got go=%b cnt=%0d st=%0d empty=%b exp 0/0/0/1", gate_open, count, debug_state, empty); end
        @(negedge clk);
        reset = 1'b0;
        step();
        tests++; if (debug_state !== 3'd1) begin failed++; $display("FAIL post_reset_reeval got %0d exp 1", debug_state); end
        car_waiting = 1'b0;
        for (int i = 0; i < 15; i++) pulse(1'b1, 1'b0);
        tests++; if (count !== 4'd15 || full !== 1'b1 || ovf_err !== 1'b0) begin failed++; $display("FAIL cap_restored got cnt=%0d full=%b ovf=%b exp 15/1/0", count, full, ovf_err); end
        pulse(1'b1, 1'b0);
        tests++; if (count !== 4'd15 || ovf_err !== 1'b1) begin failed++; $display("FAIL no_wrap got cnt=%0d ovf=%b exp 15/1", count, ovf_err); end
    endtask

    initial begin
        test_reset();
        test_normal_entry();
        test_capacity();
        test_underflow_simul();
        test_full_no_abort();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
